dff_shift_reg: RTL and testbench
================================

DFF_SHIFT_REG -- requirements
Module: dff_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0 (WIDTH bits), value loaded into Q on reset and clear.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port En  input  1  update enable; 0 = hold all state.
REQ-006 SHALL have port Mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port D  input  WIDTH  parallel load data.
REQ-008 SHALL have port SinR  input  1  serial bit entering Q[WIDTH-1] on shift right.
REQ-009 SHALL have port SinL  input  1  serial bit entering Q[0] on shift left.
REQ-010 SHALL have port Q  output  WIDTH  register contents.
REQ-011 SHALL have port Qn  output  WIDTH  bitwise complement of Q.
REQ-012 SHALL have port SoutR  output  1  equal to Q[0].
REQ-013 SHALL have port SoutL  output  1  equal to Q[WIDTH-1].
REQ-014 SHALL have port Cnt  output  CW = $clog2(WIDTH+1)  shifts since last load/reset, saturating.
REQ-015 SHALL have port Done  output  1  high when Cnt == WIDTH.

Function
REQ-016 SHALL, on a rising Clk edge with En=1 and Mode=11, set Q <= D and Cnt <= 0.
REQ-017 SHALL, with En=1 and Mode=01, set Q <= {SinR, Q[WIDTH-1:1]}.
REQ-018 SHALL, with En=1 and Mode=10, set Q <= {Q[WIDTH-2:0], SinL}.
REQ-019 SHALL, with En=1 and a shift mode, increment Cnt by 1 if Cnt < WIDTH, else hold Cnt at WIDTH; Q still shifts when saturated.
REQ-020 SHALL hold Q and Cnt when En=0 or Mode=00, regardless of D, SinR, SinL.
REQ-021 SHALL update Q and Cnt with one cycle latency; Qn, SoutR, SoutL, Done are combinational from registered state, no extra cycle.
REQ-022 SHALL guarantee Qn == ~Q at all times, including during reset; Q and Qn are never equal bitwise.
REQ-023 SHALL treat a Mode change between consecutive enabled cycles as legal, each edge acting on the Mode sampled at that edge.

Reset
REQ-024 SHALL, while Rstn=0, immediately (without a Clk edge) force Q = RESET_VAL, Qn = ~RESET_VAL, Cnt = 0, Done = 0.
REQ-025 SHALL give reset priority over every other input, including mid-shift sequences; the sequence is abandoned, not resumed.
REQ-026 SHALL resume normal operation at the first rising Clk edge after Rstn deasserts.

Configuration
REQ-027 SHALL, when macro DFF_SHIFT_REG_SYNC_CLR_EN is defined, add port Clr  input  1: synchronous clear, at a rising edge sets Q <= RESET_VAL and Cnt <= 0, priority over En and Mode.
REQ-028 SHALL, when DFF_SHIFT_REG_SYNC_CLR_EN is undefined, omit the Clr port entirely with all other behaviour unchanged.

Verification (WIDTH=8, RESET_VAL=0)
REQ-029 SHALL cover: Rstn=0 asynchronously between edges after Q=8'hA5 -> Q=8'h00, Qn=8'hFF, Cnt=0, Done=0 with no Clk edge.
REQ-030 SHALL cover: load D=8'h96 (En=1, Mode=11) -> next cycle Q=8'h96, Qn=8'h69, Cnt=0, SoutR=0, SoutL=1.
REQ-031 SHALL cover: after load 8'h96, 8 shift-right edges with SinR=1 -> serial SoutR sequence 0,1,1,0,1,0,0,1, final Q=8'hFF, Cnt=8, Done=1; a 9th shift keeps Cnt=8.
REQ-032 SHALL cover: Q=8'h01, shift left with SinL=0 for 3 edges then En=0 for 2 edges with Mode=10 -> Q=8'h08, Cnt=3 held.
REQ-033 SHALL cover: alternating Mode 01/10 each cycle from Q=8'h3C, SinR=SinL=0 -> Q toggles 8'h1E, 8'h3C, Cnt increments each edge.
REQ-034 SHALL cover (macro defined): Clr=1 with En=1, Mode=11, D=8'hFF -> Q=8'h00, Cnt=0.

Source files
------------

// File: rtl/dff_shift_reg.sv
// dff_shift_reg: WIDTH-bit register that can hold, shift right, shift left or
// load in parallel. It also counts shifts since the last load or reset, and
// the count saturates at WIDTH.
// Optional feature: define DFF_SHIFT_REG_SYNC_CLR_EN to add the Clr input.
// Clr is a synchronous clear that takes priority over En and Mode.
// Qn, SoutR, SoutL and Done are decoded combinationally from registered state,
// so they track Q and Cnt with no extra cycle, including during reset.

module dff_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       Rstn,
    input  logic                       En,
    input  logic [1:0]                 Mode,
    input  logic [WIDTH-1:0]           D,
    input  logic                       SinR,
    input  logic                       SinL,
`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
    input  logic                       Clr,
`endif
    output logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           Qn,
    output logic                       SoutR,
    output logic                       SoutL,
    output logic [$clog2(WIDTH+1)-1:0] Cnt,
    output logic                       Done
);

    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_qNext;
    logic [CW-1:0]    w_cntNext;
    logic [CW-1:0]    w_cntShift;
    logic             w_clr;
    mode_e            w_mode;

`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
    assign w_clr = Clr;
`else
    assign w_clr = 1'b0;
`endif

    assign w_mode = mode_e'(Mode);

    // Saturating shift count: Q keeps shifting once the count reaches WIDTH,
    // but the count stops there.
    assign w_cntShift = (r_cnt < CNT_MAX) ? (r_cnt + CW'(1)) : CNT_MAX;

    // Next-state selection: clear beats enable, and enable gates every mode
    always_comb begin
        w_qNext   = r_q;
        w_cntNext = r_cnt;
        if (w_clr) begin
            w_qNext   = RESET_VAL;
            w_cntNext = '0;
        end else if (En) begin
            case (w_mode)
                MODE_SHR: begin
                    w_qNext   = {SinR, r_q[WIDTH-1:1]};
                    w_cntNext = w_cntShift;
                end
                MODE_SHL: begin
                    w_qNext   = {r_q[WIDTH-2:0], SinL};
                    w_cntNext = w_cntShift;
                end
                MODE_LOAD: begin
                    w_qNext   = D;
                    w_cntNext = '0;
                end
                default: begin
                    w_qNext   = r_q;
                    w_cntNext = r_cnt;
                end
            endcase
        end
    end

    // State register: reset forces the state immediately and abandons any
    // shift sequence in progress
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_q   <= RESET_VAL;
            r_cnt <= '0;
        end else begin
            r_q   <= w_qNext;
            r_cnt <= w_cntNext;
        end
    end

    assign Q     = r_q;
    assign Qn    = ~r_q;
    assign SoutR = r_q[0];
    assign SoutL = r_q[WIDTH-1];
    assign Cnt   = r_cnt;
    assign Done  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_dff_shift_reg.sv
// tb_dff_shift_reg: directed checks of dff_shift_reg with WIDTH=8 and RESET_VAL=0.
// Each expected value is worked out by hand.
// The Clr checks are included only when DFF_SHIFT_REG_SYNC_CLR_EN is defined.

module tb_dff_shift_reg;

    logic       Clk;
    logic       Rstn;
    logic       En;
    logic [1:0] Mode;
    logic [7:0] D;
    logic       SinR;
    logic       SinL;
`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
    logic       Clr;
`endif
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       SoutR;
    logic       SoutL;
    logic [3:0] Cnt;
    logic       Done;

    int total;
    int bad;

    dff_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .Clk   (Clk),
        .Rstn  (Rstn),
        .En    (En),
        .Mode  (Mode),
        .D     (D),
        .SinR  (SinR),
        .SinL  (SinL),
`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
        .Clr   (Clr),
`endif
        .Q     (Q),
        .Qn    (Qn),
        .SoutR (SoutR),
        .SoutL (SoutL),
        .Cnt   (Cnt),
        .Done  (Done)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive one set of inputs, take one rising edge, and settle 1 time unit past it.
    task automatic applyStimulus(input logic en, input logic [1:0] mode,
                                 input logic [7:0] d, input logic sinR,
                                 input logic sinL);
        En   = en;
        Mode = mode;
        D    = d;
        SinR = sinR;
        SinL = sinL;
        @(posedge Clk);
        #1;
    endtask

    // Count one comparison. On a mismatch, count a failure and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        logic [7:0] soutSeq;
        total = 0;
        bad   = 0;
        Rstn  = 1'b0;
        En    = 1'b0;
        Mode  = 2'b00;
        D     = 8'h00;
        SinR  = 1'b0;
        SinL  = 1'b0;
`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
        Clr   = 1'b0;
`endif
        #2;
        $display("[TB] reset state");
        checkOutput("rst_Q",    32'(Q),    32'h00);
        checkOutput("rst_Qn",   32'(Qn),   32'hFF);
        checkOutput("rst_Cnt",  32'(Cnt),  32'h0);
        checkOutput("rst_Done", 32'(Done), 32'h0);

        @(negedge Clk);
        Rstn = 1'b1;
        applyStimulus(1'b0, 2'b11, 8'h5A, 1'b1, 1'b1);
        checkOutput("hold_en0_Q", 32'(Q), 32'h00);

        // Load A5, then assert reset between edges
        applyStimulus(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
        checkOutput("loadA5_Q",  32'(Q),  32'hA5);
        checkOutput("loadA5_Qn", 32'(Qn), 32'h5A);
        applyStimulus(1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        checkOutput("shrA5_Q",   32'(Q),   32'h52);
        checkOutput("shrA5_Cnt", 32'(Cnt), 32'h1);
        applyStimulus(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
        checkOutput("reloadA5_Q", 32'(Q), 32'hA5);
        #2;
        Rstn = 1'b0;
        #1;
        checkOutput("async_Q",    32'(Q),    32'h00);
        checkOutput("async_Qn",   32'(Qn),   32'hFF);
        checkOutput("async_Cnt",  32'(Cnt),  32'h0);
        checkOutput("async_Done", 32'(Done), 32'h0);

        // While reset is held, a load request must have no effect
        En   = 1'b1;
        Mode = 2'b11;
        D    = 8'hFF;
        @(posedge Clk);
        #1;
        checkOutput("rst_prio_Q", 32'(Q), 32'h00);
        Rstn = 1'b1;
        applyStimulus(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        checkOutput("resume_Q", 32'(Q), 32'hFF);

        // Load 96 and shift it out to the right
        $display("[TB] load 96 and shift right");
        applyStimulus(1'b1, 2'b11, 8'h96, 1'b0, 1'b0);
        checkOutput("load96_Q",     32'(Q),     32'h96);
        checkOutput("load96_Qn",    32'(Qn),    32'h69);
        checkOutput("load96_Cnt",   32'(Cnt),   32'h0);
        checkOutput("load96_SoutR", 32'(SoutR), 32'h0);
        checkOutput("load96_SoutL", 32'(SoutL), 32'h1);
        soutSeq = 8'b1001_0110;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("soutR_%0d", i), 32'(SoutR), 32'(soutSeq[i]));
            applyStimulus(1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("shr_cnt_%0d", i), 32'(Cnt), 32'(i + 1));
            checkOutput($sformatf("shr_done_%0d", i), 32'(Done), (i == 7) ? 32'h1 : 32'h0);
        end
        checkOutput("shr8_Q",  32'(Q),  32'hFF);
        checkOutput("shr8_Qn", 32'(Qn), 32'h00);
        applyStimulus(1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        checkOutput("shr9_Q",    32'(Q),    32'h7F);
        checkOutput("shr9_Cnt",  32'(Cnt),  32'h8);
        checkOutput("shr9_Done", 32'(Done), 32'h1);

        // Shift left three times, then hold with En low
        $display("[TB] shift left then hold");
        applyStimulus(1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
        checkOutput("load01_Cnt", 32'(Cnt), 32'h0);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        checkOutput("shl1_Q", 32'(Q), 32'h02);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        checkOutput("shl2_Q", 32'(Q), 32'h04);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        checkOutput("shl3_Q",   32'(Q),   32'h08);
        checkOutput("shl3_Cnt", 32'(Cnt), 32'h3);
        applyStimulus(1'b0, 2'b10, 8'hC3, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b10, 8'h3C, 1'b1, 1'b1);
        checkOutput("hold_Q",    32'(Q),    32'h08);
        checkOutput("hold_Cnt",  32'(Cnt),  32'h3);
        checkOutput("hold_Done", 32'(Done), 32'h0);
        applyStimulus(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1);
        checkOutput("mode00_Q",   32'(Q),   32'h08);
        checkOutput("mode00_Cnt", 32'(Cnt), 32'h3);

        // Alternate the shift direction on every edge
        $display("[TB] alternating modes");
        applyStimulus(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        checkOutput("alt1_Q",   32'(Q),   32'h1E);
        checkOutput("alt1_Cnt", 32'(Cnt), 32'h1);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        checkOutput("alt2_Q",   32'(Q),   32'h3C);
        checkOutput("alt2_Cnt", 32'(Cnt), 32'h2);
        applyStimulus(1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        checkOutput("alt3_Q",   32'(Q),   32'h1E);
        checkOutput("alt3_Cnt", 32'(Cnt), 32'h3);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        checkOutput("alt4_Q",   32'(Q),   32'h3C);
        checkOutput("alt4_Cnt", 32'(Cnt), 32'h4);
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
        checkOutput("shl_sin1_Q",     32'(Q),     32'h79);
        checkOutput("shl_sin1_SoutR", 32'(SoutR), 32'h1);
        checkOutput("shl_sin1_SoutL", 32'(SoutL), 32'h0);

`ifdef DFF_SHIFT_REG_SYNC_CLR_EN
        // A synchronous clear wins over a parallel load on the same edge
        $display("[TB] synchronous clear");
        Clr = 1'b1;
        applyStimulus(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        checkOutput("clr_Q",   32'(Q),   32'h00);
        checkOutput("clr_Cnt", 32'(Cnt), 32'h0);
        Clr = 1'b0;
        applyStimulus(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        checkOutput("postclr_Q", 32'(Q), 32'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
